// File: rtl/hyst_pkg.sv
// Shared definitions for the systolic MAC processing element: default widths,
// FSM state encoding and saturation limit helpers.
package hyst_pkg;

  localparam int DEF_REG_WIDTH  = 16;
  localparam int DEF_VECTOR     = 2;
  localparam int DEF_ACC_WIDTH  = 40;
  localparam int DEF_KLEN_WIDTH = 8;

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, HOLD} pe_state_t;

  // Limits are returned sign-extended to 64 bits; callers truncate to their width.
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int w);
    return ~((64'd1 << (w - 1)) - 64'd1);
  endfunction

endpackage

// File: rtl/pe_mult_stage.sv
// First MAC pipeline stage: registers the per-lane signed products of an
// accepted beat together with its valid/last sideband.
module pe_mult_stage
  import hyst_pkg::*;
#(
  parameter int REG_WIDTH = DEF_REG_WIDTH,
  parameter int VECTOR    = DEF_VECTOR
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_fire,
  input  logic                          in_last,
  input  logic signed [REG_WIDTH-1:0]   a_in [VECTOR-1:0],
  input  logic signed [REG_WIDTH-1:0]   b_in [VECTOR-1:0],
  output logic signed [2*REG_WIDTH-1:0] p    [VECTOR-1:0],
  output logic                          s1_valid,
  output logic                          s1_last
);

  localparam int PW = 2 * REG_WIDTH;

  for (genvar gi = 0; gi < VECTOR; gi++) begin : g_lane
    always_ff @(posedge clk) begin
      if (rst) begin
        p[gi] <= '0;
      end else if (in_fire) begin
        p[gi] <= PW'(a_in[gi]) * PW'(b_in[gi]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
    end else begin
      s1_valid <= in_fire;
      s1_last  <= in_fire & in_last;
    end
  end

endmodule

// File: rtl/systolic_pe_mac.sv
// Systolic-array MAC processing element: accumulates k_len lane dot products
// per tile and presents the result on a valid/ready register. Saturating
// accumulation is enabled by defining HYST_PE_SATURATE_EN.
module systolic_pe_mac
  import hyst_pkg::*;
#(
  parameter int REG_WIDTH  = DEF_REG_WIDTH,
  parameter int VECTOR     = DEF_VECTOR,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int KLEN_WIDTH = DEF_KLEN_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [REG_WIDTH-1:0] a_in [VECTOR-1:0],
  input  logic signed [REG_WIDTH-1:0] b_in [VECTOR-1:0],
  input  logic [KLEN_WIDTH-1:0]       k_len,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ACC_WIDTH-1:0]        acc_out,
  output logic                        ovf
);

  localparam int PW = 2 * REG_WIDTH;

  pe_state_t             state_reg, state_next;
  logic [KLEN_WIDTH-1:0] count_reg, count_next;
  logic [KLEN_WIDTH-1:0] klen_reg, klen_next;
  logic [KLEN_WIDTH-1:0] klen_eff;
  logic                  in_fire, out_fire, beat_last;
  logic signed [PW-1:0]  p [VECTOR-1:0];
  logic                  s1_valid, s1_last;
  logic [ACC_WIDTH-1:0]  acc_reg, lane_sum, add_result;

  assign in_ready = !rst && (state_reg == IDLE || state_reg == ACCUM);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign klen_eff = (k_len == '0) ? KLEN_WIDTH'(1) : k_len;

  pe_mult_stage #(
    .REG_WIDTH(REG_WIDTH),
    .VECTOR   (VECTOR)
  ) u_mult (
    .clk     (clk),
    .rst     (rst),
    .in_fire (in_fire),
    .in_last (beat_last),
    .a_in    (a_in),
    .b_in    (b_in),
    .p       (p),
    .s1_valid(s1_valid),
    .s1_last (s1_last)
  );

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    klen_next  = klen_reg;
    beat_last  = 1'b0;
    case (state_reg)
      IDLE: begin
        beat_last = (klen_eff == KLEN_WIDTH'(1));
        if (in_fire) begin
          klen_next  = klen_eff;
          count_next = KLEN_WIDTH'(1);
          state_next = beat_last ? FLUSH : ACCUM;
        end
      end
      ACCUM: begin
        beat_last = (count_reg == klen_reg - KLEN_WIDTH'(1));
        if (in_fire) begin
          count_next = count_reg + KLEN_WIDTH'(1);
          if (beat_last) state_next = FLUSH;
        end
      end
      FLUSH: begin
        if (s1_valid && s1_last) state_next = HOLD;
      end
      HOLD: begin
        if (out_fire) begin
          state_next = IDLE;
          count_next = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Lane products are sign-extended to the accumulator width before summing.
  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < VECTOR; i++) begin
      lane_sum = lane_sum + {{(ACC_WIDTH - PW){p[i][PW-1]}}, p[i]};
    end
  end

`ifdef HYST_PE_SATURATE_EN
  logic [ACC_WIDTH-1:0] raw_sum;
  logic                 sat_hit, ovf_tile_reg, ovf_reg;

  always_comb begin
    raw_sum    = acc_reg + lane_sum;
    sat_hit    = (acc_reg[ACC_WIDTH-1] == lane_sum[ACC_WIDTH-1]) &&
                 (raw_sum[ACC_WIDTH-1] != acc_reg[ACC_WIDTH-1]);
    add_result = raw_sum;
    if (sat_hit) begin
      add_result = acc_reg[ACC_WIDTH-1] ? ACC_WIDTH'(sat_min(ACC_WIDTH))
                                        : ACC_WIDTH'(sat_max(ACC_WIDTH));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_tile_reg <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      if (s1_valid) begin
        if (s1_last) begin
          ovf_reg      <= ovf_tile_reg | sat_hit;
          ovf_tile_reg <= 1'b0;
        end else begin
          ovf_tile_reg <= ovf_tile_reg | sat_hit;
        end
      end
      if (out_fire) ovf_reg <= 1'b0;
    end
  end

  assign ovf = ovf_reg;
`else
  assign add_result = acc_reg + lane_sum;
  assign ovf        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      count_reg <= '0;
      klen_reg  <= '0;
      acc_reg   <= '0;
      acc_out   <= '0;
      out_valid <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      klen_reg  <= klen_next;
      if (s1_valid) begin
        if (s1_last) begin
          acc_out   <= add_result;
          out_valid <= 1'b1;
          acc_reg   <= '0;
        end else begin
          acc_reg <= add_result;
        end
      end
      if (out_fire) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_systolic_pe_mac.sv
// Self-checking bench for systolic_pe_mac: table-driven tiles, directed
// corner sequences and randomized tiles against a plain-arithmetic model.
module tb_systolic_pe_mac;

  localparam int RW  = 16;
  localparam int V   = 2;
  localparam int AW  = 40;
  localparam int KW  = 8;
  localparam int AW2 = 33;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, in_valid, out_ready;
  logic [KW-1:0]        k_len;
  logic signed [RW-1:0] a_in [V-1:0];
  logic signed [RW-1:0] b_in [V-1:0];
  logic                 in_ready, out_valid, ovf;
  logic [AW-1:0]        acc_out;
  logic                 in_ready2, out_valid2, ovf2;
  logic [AW2-1:0]       acc_out2;

  systolic_pe_mac #(.REG_WIDTH(RW), .VECTOR(V), .ACC_WIDTH(AW), .KLEN_WIDTH(KW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .k_len(k_len), .out_valid(out_valid),
    .out_ready(out_ready), .acc_out(acc_out), .ovf(ovf));

  systolic_pe_mac #(.REG_WIDTH(RW), .VECTOR(V), .ACC_WIDTH(AW2), .KLEN_WIDTH(KW)) dut_w33 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .a_in(a_in), .b_in(b_in), .k_len(k_len), .out_valid(out_valid2),
    .out_ready(out_ready), .acc_out(acc_out2), .ovf(ovf2));

  int checks = 0;
  int errors = 0;

  typedef struct {
    int     kl;
    int     nb;
    int     hold;
    int     a0[4];
    int     a1[4];
    int     b0[4];
    int     b1[4];
    longint exp;
  } vec_t;

  vec_t vecs[5];
  int   ba0[8], ba1[8], bb0[8], bb1[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] m40(input longint v);
    return {24'd0, AW'(v)};
  endfunction

  // Model of one accumulate step: exact sum, clamped when saturation is built in.
  function automatic longint add_model(input longint acc, input longint x, input int w);
    longint s, hi, lo;
    s  = acc + x;
    hi = (64'sd1 <<< (w - 1)) - 1;
    lo = -(64'sd1 <<< (w - 1));
`ifdef HYST_PE_SATURATE_EN
    if (s > hi) s = hi;
    if (s < lo) s = lo;
`endif
    return s;
  endfunction

  task automatic send_beat(input int a0, input int a1, input int b0, input int b1,
                           input int kl, input int pre_idle);
    int guard;
    repeat (pre_idle) begin
      in_valid = 1'b0;
      a_in[0] = RW'($urandom); a_in[1] = RW'($urandom);
      b_in[0] = RW'($urandom); b_in[1] = RW'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b1;
    a_in[0] = RW'(a0); a_in[1] = RW'(a1);
    b_in[0] = RW'(b0); b_in[1] = RW'(b1);
    k_len = KW'(kl);
    guard = 0;
    while (!in_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready stayed 0, expected 1");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Called at the negedge right after the last beat's accepting edge.
  task automatic finish_tile(input string name, input logic [63:0] exp1, input logic exp_ovf1,
                             input int hold, input bit chk2, input logic [63:0] exp2,
                             input logic exp_ovf2);
    check({name, "/lat0_valid"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    check({name, "/lat1_valid"}, 64'(out_valid), 64'd1);
    check({name, "/acc"}, {24'd0, acc_out}, exp1);
    check({name, "/ovf"}, 64'(ovf), 64'(exp_ovf1));
    if (chk2) begin
      check({name, "/acc_w33"}, {31'd0, acc_out2}, exp2);
      check({name, "/ovf_w33"}, 64'(ovf2), 64'(exp_ovf2));
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({name, "/hold_in_ready"}, 64'(in_ready), 64'd0);
      check({name, "/hold_valid"}, 64'(out_valid), 64'd1);
      check({name, "/hold_acc"}, {24'd0, acc_out}, exp1);
    end
    $display("tile %s: acc_out=0x%0h ovf=%0b", name, acc_out, ovf);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "/release_valid"}, 64'(out_valid), 64'd0);
    check({name, "/release_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    longint exp;
    bit     seen;
    int     kl, nb;

    vecs[0] = '{kl:3, nb:3, hold:0, a0:'{1, -1, 0, 0}, a1:'{2, 5, 7, 0},
                b0:'{3, 2, 9, 0}, b1:'{4, 2, -1, 0}, exp:12};
    vecs[1] = '{kl:1, nb:1, hold:5, a0:'{100, 0, 0, 0}, a1:'{0, 0, 0, 0},
                b0:'{100, 0, 0, 0}, b1:'{0, 0, 0, 0}, exp:10000};
    vecs[2] = '{kl:0, nb:1, hold:0, a0:'{-32768, 0, 0, 0}, a1:'{-32768, 0, 0, 0},
                b0:'{-32768, 0, 0, 0}, b1:'{-32768, 0, 0, 0}, exp:64'sh80000000};
    vecs[3] = '{kl:2, nb:2, hold:1, a0:'{32767, 32767, 0, 0}, a1:'{32767, 32767, 0, 0},
                b0:'{32767, 32767, 0, 0}, b1:'{32767, 32767, 0, 0}, exp:64'shFFFC0004};
    vecs[4] = '{kl:2, nb:2, hold:2, a0:'{-3, 1, 0, 0}, a1:'{4, 1, 0, 0},
                b0:'{5, 1, 0, 0}, b1:'{-6, 1, 0, 0}, exp:-37};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; k_len = '0;
    a_in[0] = '0; a_in[1] = '0; b_in[0] = '0; b_in[1] = '0;
    repeat (3) @(negedge clk);
    check("reset/in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("reset/out_valid", 64'(out_valid), 64'd0);
    check("reset/acc_out", {24'd0, acc_out}, 64'd0);
    check("reset/ovf", 64'(ovf), 64'd0);
    check("reset/in_ready_after", 64'(in_ready), 64'd1);

    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < vecs[t].nb; i++) begin
        send_beat(vecs[t].a0[i], vecs[t].a1[i], vecs[t].b0[i], vecs[t].b1[i],
                  (i == 0) ? vecs[t].kl : int'($urandom_range(0, 255)), 0);
      end
      finish_tile($sformatf("table%0d", t), m40(vecs[t].exp), 1'b0, vecs[t].hold, 1'b0, 64'd0, 1'b0);
    end

    // Reset mid-tile: two beats of a four-beat tile are discarded.
    send_beat(7, 7, 7, 7, 4, 0);
    send_beat(9, 9, 9, 9, 4, 0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst/in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("midrst/no_output", 64'(seen), 64'd0);
    send_beat(2, 0, 3, 0, 1, 0);
    finish_tile("midrst_next", m40(6), 1'b0, 0, 1'b0, 64'd0, 1'b0);

    // Overflow: the 33-bit instance overflows, the 40-bit one does not.
    for (int i = 0; i < 4; i++) send_beat(-32768, -32768, -32768, -32768, 4, 0);
`ifdef HYST_PE_SATURATE_EN
    finish_tile("overflow", m40(64'sh200000000), 1'b0, 0, 1'b1, 64'hFFFFFFFF, 1'b1);
`else
    finish_tile("overflow", m40(64'sh200000000), 1'b0, 0, 1'b1, 64'h0, 1'b0);
`endif

    // Stalls: in_valid pattern 1,0,0,1,0,1.
    send_beat(11, -4, 6, 3, 3, 0);
    send_beat(-200, 50, 7, -9, 3, 2);
    send_beat(1000, 1000, -3, 2, 3, 1);
    exp = 0;
    exp = add_model(exp, 11 * 6 + (-4) * 3, AW);
    exp = add_model(exp, (-200) * 7 + 50 * (-9), AW);
    exp = add_model(exp, 1000 * (-3) + 1000 * 2, AW);
    finish_tile("stall", m40(exp), 1'b0, 0, 1'b0, 64'd0, 1'b0);

    for (int t = 0; t < 25; t++) begin
      kl = int'($urandom_range(0, 6));
      nb = (kl == 0) ? 1 : kl;
      exp = 0;
      for (int i = 0; i < nb; i++) begin
        ba0[i] = int'($urandom_range(0, 65535)) - 32768;
        ba1[i] = int'($urandom_range(0, 65535)) - 32768;
        bb0[i] = int'($urandom_range(0, 65535)) - 32768;
        bb1[i] = int'($urandom_range(0, 65535)) - 32768;
        exp = add_model(exp, longint'(ba0[i]) * bb0[i] + longint'(ba1[i]) * bb1[i], AW);
      end
      for (int i = 0; i < nb; i++) begin
        send_beat(ba0[i], ba1[i], bb0[i], bb1[i],
                  (i == 0) ? kl : int'($urandom_range(0, 255)), int'($urandom_range(0, 2)));
      end
      finish_tile($sformatf("rand%0d", t), m40(exp), 1'b0, int'($urandom_range(0, 3)),
                  1'b0, 64'd0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
